// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision sequential adder:
// default geometry, FSM state type and counter-width helper.
package mp_add_pkg;

    localparam int unsigned DEF_WIDTH = 32'd32;
    localparam int unsigned DEF_WORDS = 32'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Word counter needs at least one bit even for single-word packets.
    function automatic int unsigned cnt_width(input int unsigned words);
        int unsigned w;
        if (words > 32'd1) begin
            w = $clog2(words);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/word_add_cin.sv
// Combinational WIDTH-bit adder with carry-in; the extra top bit of the
// internal sum is the carry-out, so all-ones + all-ones + 1 keeps its carry.
module word_add_cin #(
    parameter int unsigned WIDTH = 32'd32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] full_s;

    // WIDTH+1-bit addition of both operands and the incoming carry.
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

    assign sum  = full_s[WIDTH-1:0];
    assign cout = full_s[WIDTH];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision sequential adder: one WIDTH-bit word pair per cycle,
// least-significant word first, carry chained through a register.
// Optional feature macro: MP_ADD_SUB_EN adds sub_in for A-B packets.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned WORDS = DEF_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef MP_ADD_SUB_EN
    input  logic             sub_in,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_out,
    output logic             out_last,
    output logic             out_carry
);

    localparam int unsigned    CW       = cnt_width(WORDS);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WORDS - 32'd1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              last_q, last_d;
    logic              cout_q, cout_d;
`ifdef MP_ADD_SUB_EN
    logic              sub_q, sub_d;
`endif

    logic              accept_s;
    logic              first_s;
    logic              last_word_s;
    logic              sub_eff_s;
    logic [WIDTH-1:0]  b_eff_s;
    logic              cin_s;
    logic [WIDTH-1:0]  sum_s;
    logic              cout_s;

    // Single output register: room exists whenever it is empty or being popped.
    assign in_ready = !valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

    // Operand conditioning: packet-start detection, subtract select, carry-in.
    always_comb begin
        case (state_q)
            ST_IDLE: first_s = 1'b1;
            ST_RUN:  first_s = 1'b0;
            default: first_s = 1'b1;
        endcase
        last_word_s = (cnt_q == LAST_CNT);
`ifdef MP_ADD_SUB_EN
        if (first_s) begin
            sub_eff_s = sub_in;
        end else begin
            sub_eff_s = sub_q;
        end
`else
        sub_eff_s = 1'b0;
`endif
        if (sub_eff_s) begin
            b_eff_s = ~b_in;
        end else begin
            b_eff_s = b_in;
        end
        // First word takes 0 for add or 1 for two's-complement subtract.
        if (first_s) begin
            cin_s = sub_eff_s;
        end else begin
            cin_s = carry_q;
        end
    end

    word_add_cin #(
        .WIDTH(WIDTH)
    ) u_word_add (
        .a   (a_in),
        .b   (b_eff_s),
        .cin (cin_s),
        .sum (sum_s),
        .cout(cout_s)
    );

    // Next-state: load a new word on accept, otherwise drain or hold output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        valid_d = valid_q;
        s_d     = s_q;
        last_d  = last_q;
        cout_d  = cout_q;
`ifdef MP_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        if (accept_s) begin
            valid_d = 1'b1;
            s_d     = sum_s;
`ifdef MP_ADD_SUB_EN
            sub_d   = sub_eff_s;
`endif
            if (last_word_s) begin
                // Carry is cleared so it can never leak into the next packet.
                last_d  = 1'b1;
                cout_d  = cout_s;
                carry_d = 1'b0;
                cnt_d   = {CW{1'b0}};
                state_d = ST_IDLE;
            end else begin
                last_d  = 1'b0;
                cout_d  = 1'b0;
                carry_d = cout_s;
                cnt_d   = cnt_q + CW'(1);
                state_d = ST_RUN;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            s_q     <= {WIDTH{1'b0}};
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            s_q     <= s_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
`ifdef MP_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign s_out     = s_q;
    assign out_last  = last_q;
    assign out_carry = cout_q;

endmodule
